// File: rtl/qeciphy_tx_lane_controller.sv
// qeciphy_tx_lane_controller
// Per-lane OFF/IDLE/ACTIVE TX state controller. Each lane advances only on
// its own frame-alignment boundary strobe. A lane reaching ACTIVE must first
// dwell MIN_IDLE_FRAMES boundaries in IDLE, both on bring-up and after
// dropping back from ACTIVE. all_active_o is the AND of every lane's
// registered ACTIVE flag.
module qeciphy_tx_lane_controller #(
  parameter int NUM_LANES       = 4,
  parameter int MIN_IDLE_FRAMES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_LANES-1:0] almost_faw_boundary_i,
  input  logic [NUM_LANES-1:0] link_enable_i,
  input  logic [NUM_LANES-1:0] data_enable_i,
  output logic [NUM_LANES-1:0] tx_off_o,
  output logic [NUM_LANES-1:0] tx_idle_o,
  output logic [NUM_LANES-1:0] tx_active_o,
  output logic [NUM_LANES-1:0] state_change_o,
  output logic                 all_active_o
);

  // Dwell counter only needs to reach MIN_IDLE_FRAMES; keep at least one bit.
  localparam int CNT_W = ($clog2(MIN_IDLE_FRAMES + 1) > 1) ? $clog2(MIN_IDLE_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_IDLE_FRAMES);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } lane_state_e;

  logic [NUM_LANES-1:0] tx_active_s;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_state_e      state_r;
    lane_state_e      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             off_r;
    logic             idle_r;
    logic             active_r;
    logic             change_r;

    // Next state and dwell count as they would be taken at a boundary.
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (!link_enable_i[k]) begin
        // Link loss wins over everything, including a pending data request.
        state_nxt_s = ST_OFF;
        cnt_nxt_s   = CNT_ZERO;
      end else begin
        case (state_r)
          ST_OFF: begin
            // OFF always passes through IDLE so boundary characters start first.
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
          ST_IDLE: begin
            if ((cnt_r == MIN_CNT) && data_enable_i[k]) begin
              state_nxt_s = ST_ACTIVE;
            end else if (cnt_r != MIN_CNT) begin
              cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
              cnt_nxt_s = cnt_r;
            end
          end
          ST_ACTIVE: begin
            if (!data_enable_i[k]) begin
              // Restart the dwell so the lane cannot bounce straight back.
              state_nxt_s = ST_IDLE;
              cnt_nxt_s   = CNT_ZERO;
            end else begin
              state_nxt_s = ST_ACTIVE;
            end
          end
          default: begin
            state_nxt_s = ST_OFF;
            cnt_nxt_s   = CNT_ZERO;
          end
        endcase
      end
    end

    // Lane FSM: updates state, dwell count, decoded outputs and change pulse.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_r  <= ST_OFF;
        cnt_r    <= CNT_ZERO;
        off_r    <= 1'b1;
        idle_r   <= 1'b0;
        active_r <= 1'b0;
        change_r <= 1'b0;
      end else if (almost_faw_boundary_i[k]) begin
        state_r  <= state_nxt_s;
        cnt_r    <= cnt_nxt_s;
        off_r    <= (state_nxt_s == ST_OFF);
        idle_r   <= (state_nxt_s == ST_IDLE);
        active_r <= (state_nxt_s == ST_ACTIVE);
        change_r <= (state_nxt_s != state_r);
      end else begin
        change_r <= 1'b0;
      end
    end

    assign tx_off_o[k]       = off_r;
    assign tx_idle_o[k]      = idle_r;
    assign tx_active_s[k]    = active_r;
    assign state_change_o[k] = change_r;
  end

  assign tx_active_o  = tx_active_s;
  assign all_active_o = &tx_active_s;

endmodule

// File: doc/qeciphy_tx_lane_controller.md
# qeciphy_tx_lane_controller

Multi-lane, parametrised TX state controller for the QECIPHY TX subsystem. It keeps an independent OFF/IDLE/ACTIVE state machine per lane and changes state only on that lane's frame-alignment boundary. Unlike a single-lane controller, a lane cannot jump from OFF to ACTIVE, and re-entering ACTIVE after an idle period is also gated: the lane must first spend a programmable minimum number of boundaries in IDLE. Outputs drive the per-lane packet generators, plus an aggregate all-lanes-active flag for the link layer.

## Interface
- NUM_LANES, default 4: number of independent lanes; legal range 1..32.
- MIN_IDLE_FRAMES, default 2: number of boundaries a lane must spend in IDLE before ACTIVE is permitted; legal range 0..255.
- CNT_W, derived: max(1, $clog2(MIN_IDLE_FRAMES+1)); not overridable.

Ports:
- clk_i  input  1  single clock; all logic synchronous to its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- almost_faw_boundary_i  input  NUM_LANES  per-lane strobe, one cycle ahead of that lane's FAW boundary.
- link_enable_i  input  NUM_LANES  per-lane link enable.
- data_enable_i  input  NUM_LANES  per-lane data transmission enable.
- tx_off_o  output  NUM_LANES  lane k OFF: idle words only, no boundary characters.
- tx_idle_o  output  NUM_LANES  lane k IDLE: idle words plus boundary characters.
- tx_active_o  output  NUM_LANES  lane k ACTIVE: user data plus boundary characters.
- state_change_o  output  NUM_LANES  one-cycle pulse, asserted in the first cycle lane k shows a new state.
- all_active_o  output  1  AND of all tx_active_o bits.

## Operation
- Each lane holds a 2-bit state register, one-hot decoded to off/idle/active, plus a CNT_W-bit dwell counter `cnt[k]`.
- Lanes are fully independent. No lane's inputs affect another lane's state.
- The state register and `cnt[k]` are evaluated only in cycles where almost_faw_boundary_i[k]=1. In all other cycles both hold.
- Transitions at a boundary, in priority order:
  - link_enable_i[k]=0: go to OFF and set cnt=0, from any state.
  - OFF with link_enable_i[k]=1: go to IDLE and set cnt=0. data_enable_i[k] is ignored; OFF never goes directly to ACTIVE.
  - IDLE with cnt==MIN_IDLE_FRAMES and data_enable_i[k]=1: go to ACTIVE.
  - IDLE, all other cases: stay IDLE. cnt increments, saturating at MIN_IDLE_FRAMES.
  - ACTIVE with data_enable_i[k]=0: go to IDLE and set cnt=0. The full dwell must be repeated before ACTIVE is permitted again.
  - ACTIVE with data_enable_i[k]=1: stay ACTIVE.
- With MIN_IDLE_FRAMES=0, IDLE goes to ACTIVE at the first boundary spent in IDLE, provided data_enable_i[k]=1.
- Exactly one of tx_off_o[k], tx_idle_o[k], tx_active_o[k] is high at all times, including during and after reset.
- state_change_o[k] is registered. It is high for exactly one cycle: the cycle in which the new state first appears on the outputs. It stays low when a boundary results in the same state.
- all_active_o is combinational from the registered tx_active_o bits. It carries no extra latency.

## Timing
- Reset (rst_i=1 at a clock edge): every lane goes OFF, with tx_off_o all ones, tx_idle_o and tx_active_o zero, state_change_o zero, all cnt zero, and all_active_o=0.
- Reset has priority over a coincident boundary.
- Reset asserted mid-operation takes effect on the next edge. No change pulse is generated for the reset-forced transition.
- Latency: inputs are sampled in the boundary cycle and the new state is visible on the next cycle. That cycle is the FAW boundary itself.
- Enables are not sampled outside boundary cycles. A pulse on link_enable_i or data_enable_i between boundaries has no effect.
- Minimum OFF-to-ACTIVE path: MIN_IDLE_FRAMES+2 boundaries (one to enter IDLE, MIN_IDLE_FRAMES counting, one to enter ACTIVE).
- Simultaneous boundaries on several lanes are evaluated in parallel in the same cycle.

## Test plan
- Reset with NUM_LANES=4: assert rst_i for 2 cycles. Expect tx_off_o=4'hF, tx_idle_o=0, tx_active_o=0, state_change_o=0, all_active_o=0.
- Bring-up, MIN_IDLE_FRAMES=2, lane 0, link=data=1 held, boundaries every 8 cycles:
  - IDLE appears after boundary 1.
  - ACTIVE appears after boundary 4.
  - state_change_o[0] pulses exactly twice.
- Link drop priority: lane 1 ACTIVE; drop link_enable_i[1] and raise data_enable_i[1] at the same boundary. Expect OFF the next cycle, cnt=0, and a single change pulse.
- Re-dwell: lane 2 ACTIVE; deassert data at one boundary, then reassert it before the next.
  - Expect IDLE for 2 more boundaries.
  - Expect ACTIVE only at the 3rd boundary after the drop.
- Non-boundary insensitivity: toggle all enables for 5 cycles between boundaries. Expect no output change and no change pulse.
- Independence and aggregate:
  - Stagger the four lanes' boundaries. Expect all_active_o to rise in the cycle the last lane shows ACTIVE.
  - Drop any single lane's data enable. Expect all_active_o to fall one cycle after that lane's boundary.
  - Reset mid-bring-up. Expect all lanes OFF the next cycle.
